// File: rtl/buf_arbiter.sv
// Round-robin write arbiter plus single read port, sequencing requests onto a
// level-and-acknowledge buffer interface with full/empty rejection and ack timeout.
module buf_arbiter #(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned DATA_L = 16,
    parameter int unsigned ACK_TO = 15
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          i_wreq,
    input  logic [NREQ*DATA_L-1:0]   i_wdata,
    output logic [NREQ-1:0]          o_wdone,
    output logic                     o_wfull,
    input  logic                     i_rreq,
    output logic                     o_rdone,
    output logic [DATA_L-1:0]        o_rdata,
    output logic                     o_rempty,
    output logic                     o_err,
    output logic                     o_buf_we,
    output logic                     o_buf_re,
    output logic [DATA_L-1:0]        o_buf_din,
    input  logic [DATA_L-1:0]        i_buf_dout,
    input  logic                     i_buf_w_ack,
    input  logic                     i_buf_r_ack,
    input  logic                     i_buf_full,
    input  logic                     i_buf_avail
);

    localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_W_SET,
        S_W_CLR,
        S_R_SET,
        S_R_CLR
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [IDX_W-1:0]    r_rr_ptr, w_rr_nxt;
    logic [IDX_W-1:0]    r_gnt, w_gnt_nxt;
    logic                r_last_rd, w_last_nxt;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
    logic                r_buf_we, w_we_nxt;
    logic                r_buf_re, w_re_nxt;
    logic [DATA_L-1:0]   r_buf_din, w_din_nxt;
    logic [DATA_L-1:0]   r_rdata, w_rdata_nxt;
    logic [NREQ-1:0]     r_wdone, w_wdone_nxt;
    logic                r_wfull, w_wfull_nxt;
    logic                r_rdone, w_rdone_nxt;
    logic                r_rempty, w_rempty_nxt;
    logic                r_err, w_err_nxt;

    logic [NREQ-1:0]     w_wreq_eff;
    logic                w_any_w;
    logic                w_rd_pick;
    logic [IDX_W-1:0]    w_pick;
    logic [IDX_W:0]      w_sum;
    logic [DATA_L-1:0]   w_din;
    logic [CNT_W-1:0]    w_cnt_inc;
    logic                w_to;

    function automatic logic [NREQ-1:0] f_onehot(input logic [IDX_W-1:0] idx);
        f_onehot      = '0;
        f_onehot[idx] = 1'b1;
    endfunction

    // A requester finishing this cycle is masked so it cannot be re-granted on a stale request.
    always_comb begin
        w_wreq_eff = i_wreq & ~r_wdone & {NREQ{~i_buf_w_ack}};
        w_any_w    = |w_wreq_eff;
        w_rd_pick  = i_rreq & ~r_rdone & ~i_buf_r_ack & (~w_any_w | ~r_last_rd);
        w_pick     = '0;
        w_sum      = '0;
        for (int k = NREQ; k >= 1; k--) begin
            w_sum = {1'b0, r_rr_ptr} + (IDX_W+1)'(k);
            if (w_sum >= (IDX_W+1)'(NREQ)) begin
                w_sum = w_sum - (IDX_W+1)'(NREQ);
            end
            if (w_wreq_eff[w_sum[IDX_W-1:0]]) begin
                w_pick = w_sum[IDX_W-1:0];
            end
        end
        w_din = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_pick == IDX_W'(i)) begin
                w_din = i_wdata[i*DATA_L +: DATA_L];
            end
        end
        w_cnt_inc = r_cnt + CNT_W'(1);
        w_to      = (w_cnt_inc == CNT_W'(ACK_TO));
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt  = r_state;
        w_rr_nxt     = r_rr_ptr;
        w_gnt_nxt    = r_gnt;
        w_last_nxt   = r_last_rd;
        w_cnt_nxt    = w_cnt_inc;
        w_we_nxt     = r_buf_we;
        w_re_nxt     = r_buf_re;
        w_din_nxt    = r_buf_din;
        w_rdata_nxt  = r_rdata;
        w_wdone_nxt  = '0;
        w_wfull_nxt  = 1'b0;
        w_rdone_nxt  = 1'b0;
        w_rempty_nxt = 1'b0;
        w_err_nxt    = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (w_rd_pick) begin
                    w_last_nxt = 1'b1;
                    if (!i_buf_avail) begin
                        w_rdone_nxt  = 1'b1;
                        w_rempty_nxt = 1'b1;
                    end else begin
                        w_re_nxt    = 1'b1;
                        w_state_nxt = S_R_SET;
                    end
                end else if (w_any_w) begin
                    w_last_nxt = 1'b0;
                    w_gnt_nxt  = w_pick;
                    if (i_buf_full) begin
                        w_wdone_nxt = f_onehot(w_pick);
                        w_wfull_nxt = 1'b1;
                        w_rr_nxt    = w_pick;
                    end else begin
                        w_din_nxt   = w_din;
                        w_we_nxt    = 1'b1;
                        w_state_nxt = S_W_SET;
                    end
                end
            end
            S_W_SET: begin
                if (i_buf_w_ack) begin
                    w_we_nxt    = 1'b0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_W_CLR;
                end else if (w_to) begin
                    w_err_nxt   = 1'b1;
                    w_we_nxt    = 1'b0;
                    w_wdone_nxt = f_onehot(r_gnt);
                    w_wfull_nxt = 1'b1;
                    w_rr_nxt    = r_gnt;
                    w_state_nxt = S_IDLE;
                end
            end
            S_W_CLR: begin
                if (!i_buf_w_ack) begin
                    w_wdone_nxt = f_onehot(r_gnt);
                    w_rr_nxt    = r_gnt;
                    w_state_nxt = S_IDLE;
                end else if (w_to) begin
                    w_err_nxt   = 1'b1;
                    w_wdone_nxt = f_onehot(r_gnt);
                    w_wfull_nxt = 1'b1;
                    w_rr_nxt    = r_gnt;
                    w_state_nxt = S_IDLE;
                end
            end
            S_R_SET: begin
                if (i_buf_r_ack) begin
                    w_rdata_nxt = i_buf_dout;
                    w_re_nxt    = 1'b0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_R_CLR;
                end else if (w_to) begin
                    w_err_nxt    = 1'b1;
                    w_re_nxt     = 1'b0;
                    w_rdone_nxt  = 1'b1;
                    w_rempty_nxt = 1'b1;
                    w_state_nxt  = S_IDLE;
                end
            end
            S_R_CLR: begin
                if (!i_buf_r_ack) begin
                    w_rdone_nxt = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (w_to) begin
                    w_err_nxt    = 1'b1;
                    w_rdone_nxt  = 1'b1;
                    w_rempty_nxt = 1'b1;
                    w_state_nxt  = S_IDLE;
                end
            end
            default: begin
                w_we_nxt    = 1'b0;
                w_re_nxt    = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_rr_ptr  <= IDX_W'(NREQ - 1);
            r_gnt     <= '0;
            r_last_rd <= 1'b0;
            r_cnt     <= '0;
            r_buf_we  <= 1'b0;
            r_buf_re  <= 1'b0;
            r_buf_din <= '0;
            r_rdata   <= '0;
            r_wdone   <= '0;
            r_wfull   <= 1'b0;
            r_rdone   <= 1'b0;
            r_rempty  <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_rr_ptr  <= w_rr_nxt;
            r_gnt     <= w_gnt_nxt;
            r_last_rd <= w_last_nxt;
            r_cnt     <= w_cnt_nxt;
            r_buf_we  <= w_we_nxt;
            r_buf_re  <= w_re_nxt;
            r_buf_din <= w_din_nxt;
            r_rdata   <= w_rdata_nxt;
            r_wdone   <= w_wdone_nxt;
            r_wfull   <= w_wfull_nxt;
            r_rdone   <= w_rdone_nxt;
            r_rempty  <= w_rempty_nxt;
            r_err     <= w_err_nxt;
        end
    end

    assign o_wdone   = r_wdone;
    assign o_wfull   = r_wfull;
    assign o_rdone   = r_rdone;
    assign o_rdata   = r_rdata;
    assign o_rempty  = r_rempty;
    assign o_err     = r_err;
    assign o_buf_we  = r_buf_we;
    assign o_buf_re  = r_buf_re;
    assign o_buf_din = r_buf_din;

endmodule

// File: tb/tb_buf_arbiter.sv
// Bench for buf_arbiter: a small FIFO buffer model acks one cycle after each strobe;
// completions are checked against a scoreboard of expected outcomes.
module tb_buf_arbiter;

    localparam int unsigned NREQ   = 4;
    localparam int unsigned DATA_L = 16;

    logic clk = 1'b0;
    logic rst_n;
    logic [NREQ-1:0]        wreq;
    logic [DATA_L-1:0]      wd_arr [NREQ];
    logic [NREQ*DATA_L-1:0] wdata;
    logic                   rreq;
    logic [NREQ-1:0]        o_wdone;
    logic                   o_wfull, o_rdone, o_rempty, o_err, o_buf_we, o_buf_re;
    logic [DATA_L-1:0]      o_rdata, o_buf_din;

    logic                   force_full, tie_w_ack0;
    logic                   b_w_ack, b_r_ack;
    logic [DATA_L-1:0]      b_dout;
    logic [DATA_L-1:0]      b_mem [8];
    logic [2:0]             b_wp, b_rp;
    logic [3:0]             b_cnt;
    logic                   b_push, b_pop, b_full, b_avail;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic              rd;
        logic [1:0]        idx;
        logic              flag;
        logic [DATA_L-1:0] data;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic              rd;
        logic [1:0]        idx;
        logic [DATA_L-1:0] wd;
        logic              full;
        logic              no_ack;
        logic              exp_flag;
        int                exp_cyc;
        int                exp_strobes;
        int                exp_err;
        logic [DATA_L-1:0] exp_rdata;
    } vec_t;

    assign wdata = {wd_arr[3], wd_arr[2], wd_arr[1], wd_arr[0]};

    always #5 clk = ~clk;

    buf_arbiter #(.NREQ(NREQ), .DATA_L(DATA_L), .ACK_TO(15)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_wreq      (wreq),
        .i_wdata     (wdata),
        .o_wdone     (o_wdone),
        .o_wfull     (o_wfull),
        .i_rreq      (rreq),
        .o_rdone     (o_rdone),
        .o_rdata     (o_rdata),
        .o_rempty    (o_rempty),
        .o_err       (o_err),
        .o_buf_we    (o_buf_we),
        .o_buf_re    (o_buf_re),
        .o_buf_din   (o_buf_din),
        .i_buf_dout  (b_dout),
        .i_buf_w_ack (b_w_ack),
        .i_buf_r_ack (b_r_ack),
        .i_buf_full  (b_full),
        .i_buf_avail (b_avail)
    );

    // Buffer model: ack rises one cycle after the strobe and clears the cycle after.
    assign b_push  = o_buf_we & ~b_w_ack & ~tie_w_ack0 & (b_cnt != 4'd8);
    assign b_pop   = o_buf_re & ~b_r_ack & (b_cnt != 4'd0);
    assign b_full  = (b_cnt == 4'd8) | force_full;
    assign b_avail = (b_cnt != 4'd0);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_w_ack <= 1'b0;
            b_r_ack <= 1'b0;
            b_dout  <= '0;
            b_wp    <= '0;
            b_rp    <= '0;
            b_cnt   <= '0;
        end else begin
            b_w_ack <= o_buf_we & ~b_w_ack & ~tie_w_ack0;
            b_r_ack <= o_buf_re & ~b_r_ack;
            if (b_push) begin
                b_mem[b_wp] <= o_buf_din;
                b_wp        <= b_wp + 3'd1;
            end
            if (b_pop) begin
                b_dout <= b_mem[b_rp];
                b_rp   <= b_rp + 3'd1;
            end
            b_cnt <= b_cnt + {3'd0, b_push} - {3'd0, b_pop};
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Completion monitor: every wdone/rdone pops one expected outcome.
    always @(negedge clk) begin
        if (rst_n && (o_rdone || (o_wdone != '0))) begin
            exp_t e;
            logic [1:0] gi;
            gi = '0;
            for (int i = 0; i < NREQ; i++) if (o_wdone[i]) gi = 2'(i);
            chk("wdone_onehot", 32'($countones(o_wdone) <= 1), 32'd1);
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: wdone=%b rdone=%b with empty scoreboard", o_wdone, o_rdone);
            end else begin
                e = sb.pop_front();
                chk("done_kind", 32'(o_rdone), 32'(e.rd));
                if (e.rd) begin
                    chk("rempty", 32'(o_rempty), 32'(e.flag));
                    chk("rdata", 32'(o_rdata), 32'(e.data));
                end else begin
                    chk("grant_idx", 32'(gi), 32'(e.idx));
                    chk("wfull", 32'(o_wfull), 32'(e.flag));
                end
            end
        end
        if (rst_n && (o_buf_we || o_buf_re)) chk("we_re_exclusive", 32'(o_buf_we & o_buf_re), 32'd0);
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt [9];
        vec_t t;
        int strobes, errs, done_c, ndone;

        //          rd    idx    wd        full  noack flag  cyc str err rdata
        vt[0] = '{1'b0, 2'd0, 16'h1234, 1'b0, 1'b0, 1'b0, 4,  2,  0, 16'h0000};
        vt[1] = '{1'b1, 2'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 4,  2,  0, 16'h1234};
        vt[2] = '{1'b0, 2'd1, 16'hAAAA, 1'b0, 1'b0, 1'b0, 4,  2,  0, 16'h0000};
        vt[3] = '{1'b0, 2'd3, 16'h5555, 1'b0, 1'b0, 1'b0, 4,  2,  0, 16'h0000};
        vt[4] = '{1'b1, 2'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 4,  2,  0, 16'hAAAA};
        vt[5] = '{1'b1, 2'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 4,  2,  0, 16'h5555};
        vt[6] = '{1'b1, 2'd0, 16'h0000, 1'b0, 1'b0, 1'b1, 1,  0,  0, 16'h5555};
        vt[7] = '{1'b0, 2'd1, 16'hDEAD, 1'b0, 1'b1, 1'b1, 16, 15, 1, 16'h0000};
        vt[8] = '{1'b0, 2'd2, 16'h7777, 1'b1, 1'b0, 1'b1, 1,  0,  0, 16'h0000};

        rst_n = 1'b0; wreq = '0; rreq = 1'b0; force_full = 1'b0; tie_w_ack0 = 1'b0;
        for (int i = 0; i < NREQ; i++) wd_arr[i] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_buf_we", 32'(o_buf_we), 32'd0);
        chk("rst_buf_re", 32'(o_buf_re), 32'd0);
        chk("rst_wdone", 32'(o_wdone), 32'd0);
        chk("rst_rdone", 32'(o_rdone), 32'd0);
        chk("rst_err", 32'(o_err), 32'd0);
        chk("rst_rdata", 32'(o_rdata), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 9; v++) begin
            t = vt[v];
            @(posedge clk); #1;
            force_full = t.full;
            tie_w_ack0 = t.no_ack;
            sb.push_back('{t.rd, t.idx, t.exp_flag, t.exp_rdata});
            if (t.rd) rreq = 1'b1;
            else begin
                wd_arr[t.idx] = t.wd;
                wreq[t.idx]   = 1'b1;
            end
            strobes = 0; errs = 0; done_c = -1;
            for (int c = 0; c < 40 && done_c < 0; c++) begin
                @(negedge clk);
                if (o_buf_we || o_buf_re) strobes++;
                if (o_err) errs++;
                if (c == 1 && !t.rd && t.exp_strobes > 0) chk("buf_din", 32'(o_buf_din), 32'(t.wd));
                if (o_rdone || (o_wdone != '0)) begin
                    done_c = c;
                    wreq = '0;
                    rreq = 1'b0;
                end
            end
            chk("done_cycle", 32'(done_c), 32'(t.exp_cyc));
            chk("strobe_cycles", 32'(strobes), 32'(t.exp_strobes));
            chk("err_pulses", 32'(errs), 32'(t.exp_err));
            force_full = 1'b0;
            tie_w_ack0 = 1'b0;
            repeat (2) @(negedge clk);
        end

        // After requester 2 was rejected, the pointer sits at 2: grant 3 before 0.
        @(posedge clk); #1;
        wd_arr[3] = 16'h3333;
        wd_arr[0] = 16'h0F0F;
        sb.push_back('{1'b0, 2'd3, 1'b0, 16'h0000});
        sb.push_back('{1'b0, 2'd0, 1'b0, 16'h0000});
        wreq = 4'b1001;
        ndone = 0;
        for (int c = 0; c < 60 && ndone < 2; c++) begin
            @(negedge clk);
            if (o_wdone != '0) begin
                wreq = wreq & ~o_wdone;
                ndone++;
            end
        end
        chk("rr_after_reject_count", 32'(ndone), 32'd2);
        repeat (2) @(negedge clk);

        // Reset in W_SET, then round-robin with an interleaved read.
        @(posedge clk); #1;
        for (int i = 0; i < NREQ; i++) wd_arr[i] = 16'h1000 + 16'(i);
        wreq = 4'b1111;
        @(negedge clk);
        @(negedge clk);
        chk("pre_reset_buf_we", 32'(o_buf_we), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_buf_we", 32'(o_buf_we), 32'd0);
        chk("async_rst_buf_din", 32'(o_buf_din), 32'd0);
        chk("async_rst_rdata", 32'(o_rdata), 32'd0);
        chk("async_rst_wdone", 32'(o_wdone), 32'd0);
        sb.push_back('{1'b0, 2'd0, 1'b0, 16'h0000});
        sb.push_back('{1'b0, 2'd1, 1'b0, 16'h0000});
        sb.push_back('{1'b1, 2'd0, 1'b0, 16'h1000});
        sb.push_back('{1'b0, 2'd2, 1'b0, 16'h0000});
        sb.push_back('{1'b0, 2'd3, 1'b0, 16'h0000});
        sb.push_back('{1'b0, 2'd0, 1'b0, 16'h0000});
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < 200 && ndone < 6; c++) begin
            @(negedge clk);
            if (o_rdone || (o_wdone != '0)) begin
                ndone++;
                if (o_rdone) rreq = 1'b0;
                if (ndone == 2) rreq = 1'b1;
                if (ndone == 6) wreq = '0;
            end
        end
        chk("rr_done_count", 32'(ndone), 32'd6);
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
